// File: rtl/water_level_monitor_pkg.sv
// rtl/water_level_monitor_pkg.sv - shared state encoding and default thresholds for the tank level monitor
//
// Contents:
//   lvl_state_e      : monitor state (WARMUP, RUN, FAULT)
//   DEF_*            : default parameter values shared by the monitor, condition logic and benches
//   hyst_next()      : set/clear/hold helper for hysteresis flags

package water_level_monitor_pkg;

    typedef enum logic [1:0] {
        LVL_WARMUP = 2'd0,
        LVL_RUN    = 2'd1,
        LVL_FAULT  = 2'd2
    } lvl_state_e;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_AVG_LOG2     = 2;
    localparam int DEF_FULL_LEVEL   = 200;
    localparam int DEF_FULL_HYST    = 10;
    localparam int DEF_CRIT_LEVEL   = 40;
    localparam int DEF_CRIT_HYST    = 10;
    localparam int DEF_TIMEOUT      = 1000;
    localparam int DEF_STALL_CYCLES = 50000;

    // Set wins over clear; neither condition keeps the current value.
    function automatic logic hyst_next(input logic cur, input logic set_c, input logic clr_c);
        logic nxt;
        nxt = cur;
        if (set_c) begin
            nxt = 1'b1;
        end else if (clr_c) begin
            nxt = 1'b0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/water_level_monitor_level_averager.sv
// rtl/water_level_monitor_level_averager.sv - sliding window of level samples with running sum and average
//
// Ports:
//   clock          : rising-edge clock
//   reset          : synchronous, active-high
//   clear_i        : with sample_valid_i, restart the window holding only the new sample
//   sample_valid_i : accept sample_i this cycle
//   sample_i       : raw level reading
//   level_avg_o    : running sum >> AVG_LOG2 (truncated), registered

module level_averager
    import water_level_monitor_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             sample_valid_i,
    input  logic [WIDTH-1:0] sample_i,
    output logic [WIDTH-1:0] level_avg_o
);

    localparam int WIN   = 1 << AVG_LOG2;
    localparam int SUM_W = WIDTH + AVG_LOG2;

    // win_q[0] is the newest sample, win_q[WIN-1] the oldest.
    logic [WIDTH-1:0] win_q [WIN];
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_d;

    // The sum of WIN samples of WIDTH bits always fits in SUM_W bits.
    always_comb begin
        sum_d = sum_q + SUM_W'(sample_i) - SUM_W'(win_q[WIN-1]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < WIN; i++) begin
                win_q[i] <= '0;
            end
            sum_q <= '0;
        end else if (sample_valid_i) begin
            win_q[0] <= sample_i;
            if (clear_i) begin
                for (int i = 1; i < WIN; i++) begin
                    win_q[i] <= '0;
                end
                sum_q <= SUM_W'(sample_i);
            end else begin
                for (int i = 1; i < WIN; i++) begin
                    win_q[i] <= win_q[i-1];
                end
                sum_q <= sum_d;
            end
        end
    end

    assign level_avg_o = WIDTH'(sum_q >> AVG_LOG2);

endmodule

// File: rtl/water_level_monitor.sv
// rtl/water_level_monitor.sv - tank level conditioning: averaging, hysteresis flags, silent-sensor and fill-stall detection
//
// Optional feature macro: LEVEL_MONITOR_STALL_DETECT_EN (builds the fill-stall counter;
// when undefined fill_stall is tied low).
//
// Ports:
//   clock          : rising-edge clock
//   reset          : synchronous, active-high
//   level_sample   : raw level reading
//   sample_valid   : one-cycle strobe qualifying level_sample
//   filling        : tank FSM is in FILLING
//   level_avg      : windowed average of the last 2^AVG_LOG2 samples
//   full_tank      : average high, with hysteresis
//   critical_level : average low, with hysteresis
//   sensor_fault   : no sample for TIMEOUT-1 cycles
//   fill_stall     : filling for STALL_CYCLES cycles without reaching full

module water_level_monitor
    import water_level_monitor_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int AVG_LOG2     = DEF_AVG_LOG2,
    parameter int FULL_LEVEL   = DEF_FULL_LEVEL,
    parameter int FULL_HYST    = DEF_FULL_HYST,
    parameter int CRIT_LEVEL   = DEF_CRIT_LEVEL,
    parameter int CRIT_HYST    = DEF_CRIT_HYST,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int STALL_CYCLES = DEF_STALL_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] level_sample,
    input  logic             sample_valid,
    input  logic             filling,
    output logic [WIDTH-1:0] level_avg,
    output logic             full_tank,
    output logic             critical_level,
    output logic             sensor_fault,
    output logic             fill_stall
);

    localparam int WIN    = 1 << AVG_LOG2;
    localparam int CNT_W  = AVG_LOG2 + 1;
    localparam int IDLE_W = $clog2(TIMEOUT);
    localparam int TH_W   = WIDTH + 1;

    localparam logic [CNT_W-1:0]  WARM_LAST = CNT_W'(WIN - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    // One extra bit so CRIT_LEVEL+CRIT_HYST may exceed the sample range.
    localparam logic [TH_W-1:0] FULL_SET_TH = TH_W'(FULL_LEVEL);
    localparam logic [TH_W-1:0] FULL_CLR_TH = TH_W'(FULL_LEVEL - FULL_HYST);
    localparam logic [TH_W-1:0] CRIT_SET_TH = TH_W'(CRIT_LEVEL);
    localparam logic [TH_W-1:0] CRIT_CLR_TH = TH_W'(CRIT_LEVEL + CRIT_HYST);

    generate
        if (FULL_LEVEL <= CRIT_LEVEL + CRIT_HYST) begin : g_bad_thresholds
            $error("water_level_monitor: FULL_LEVEL must exceed CRIT_LEVEL+CRIT_HYST");
        end
        if (TIMEOUT < 2) begin : g_bad_timeout
            $error("water_level_monitor: TIMEOUT must be at least 2");
        end
    endgenerate

    lvl_state_e        state_q;
    logic [CNT_W-1:0]  warm_cnt_q;
    logic [IDLE_W-1:0] idle_q;
    logic [IDLE_W-1:0] idle_d;
    logic              full_q;
    logic              crit_q;
    logic              fault_q;
    logic              timeout_hit;
    logic [TH_W-1:0]   avg_ext;
    logic              full_set;
    logic              full_clr;
    logic              crit_set;
    logic              crit_clr;

    // The first sample after a fault restarts the window instead of shifting in.
    level_averager #(
        .WIDTH    (WIDTH),
        .AVG_LOG2 (AVG_LOG2)
    ) u_averager (
        .clock          (clock),
        .reset          (reset),
        .clear_i        (state_q == LVL_FAULT),
        .sample_valid_i (sample_valid),
        .sample_i       (level_sample),
        .level_avg_o    (level_avg)
    );

    // Idle counter saturates at TIMEOUT-1; the timeout fires only on the edge
    // that reaches it, and any sample on that edge takes priority.
    always_comb begin
        idle_d = idle_q;
        if (sample_valid) begin
            idle_d = '0;
        end else if (idle_q != IDLE_LAST) begin
            idle_d = idle_q + 1'b1;
        end
    end

    assign timeout_hit = !sample_valid && (idle_q != IDLE_LAST) && (idle_d == IDLE_LAST);

    assign avg_ext  = {1'b0, level_avg};
    assign full_set = avg_ext >= FULL_SET_TH;
    assign full_clr = avg_ext <  FULL_CLR_TH;
    assign crit_set = avg_ext <= CRIT_SET_TH;
    assign crit_clr = avg_ext >  CRIT_CLR_TH;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= LVL_WARMUP;
            warm_cnt_q <= '0;
            idle_q     <= '0;
            full_q     <= 1'b0;
            crit_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            idle_q <= idle_d;
            unique case (state_q)
                LVL_WARMUP: begin
                    full_q <= 1'b0;
                    crit_q <= 1'b0;
                    if (sample_valid) begin
                        if (warm_cnt_q == WARM_LAST) begin
                            state_q    <= LVL_RUN;
                            warm_cnt_q <= '0;
                        end else begin
                            warm_cnt_q <= warm_cnt_q + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state_q <= LVL_FAULT;
                        fault_q <= 1'b1;
                    end
                end
                LVL_RUN: begin
                    if (timeout_hit) begin
                        state_q <= LVL_FAULT;
                        fault_q <= 1'b1;
                        full_q  <= 1'b0;
                        crit_q  <= 1'b0;
                    end else begin
                        full_q <= hyst_next(full_q, full_set, full_clr);
                        crit_q <= hyst_next(crit_q, crit_set, crit_clr);
                    end
                end
                LVL_FAULT: begin
                    full_q <= 1'b0;
                    crit_q <= 1'b0;
                    if (sample_valid) begin
                        fault_q <= 1'b0;
                        // This sample is the first of the new window.
                        if (WIN == 1) begin
                            state_q    <= LVL_RUN;
                            warm_cnt_q <= '0;
                        end else begin
                            state_q    <= LVL_WARMUP;
                            warm_cnt_q <= CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q    <= LVL_WARMUP;
                    warm_cnt_q <= '0;
                    full_q     <= 1'b0;
                    crit_q     <= 1'b0;
                    fault_q    <= 1'b0;
                end
            endcase
        end
    end

    assign full_tank      = full_q;
    assign critical_level = crit_q;
    assign sensor_fault   = fault_q;

`ifdef LEVEL_MONITOR_STALL_DETECT_EN
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES);

    logic [STALL_W-1:0] stall_cnt_q;
    logic [STALL_W-1:0] stall_cnt_d;
    logic               stall_q;
    logic               stall_d;

    // Reaching full clears the count but not an already-raised stall; only
    // the end of filling releases it.
    always_comb begin
        stall_cnt_d = '0;
        stall_d     = 1'b0;
        if (filling) begin
            stall_d = stall_q;
            if (!full_q) begin
                stall_cnt_d = (stall_cnt_q == STALL_LAST) ? stall_cnt_q : stall_cnt_q + 1'b1;
            end
            if (stall_cnt_d == STALL_LAST) begin
                stall_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
        end
    end

    assign fill_stall = stall_q;
`else
    logic unused_stall;
    assign unused_stall = filling ^ (STALL_CYCLES != 0);
    assign fill_stall   = 1'b0;
`endif

endmodule

// File: tb/tb_water_level_monitor.sv
// tb/tb_water_level_monitor.sv - scoreboard bench for water_level_monitor with a sample-history reference model

module tb_water_level_monitor;

    localparam int WIDTH        = 8;
    localparam int AVG_LOG2     = 2;
    localparam int WIN          = 4;
    localparam int FULL_LEVEL   = 200;
    localparam int FULL_HYST    = 10;
    localparam int CRIT_LEVEL   = 40;
    localparam int CRIT_HYST    = 10;
    localparam int TIMEOUT      = 16;
    localparam int STALL_CYCLES = 20;
`ifdef LEVEL_MONITOR_STALL_DETECT_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] level_sample;
    logic             sample_valid;
    logic             filling;
    logic [WIDTH-1:0] level_avg;
    logic             full_tank;
    logic             critical_level;
    logic             sensor_fault;
    logic             fill_stall;

    always #5 clk = ~clk;

    water_level_monitor #(
        .WIDTH        (WIDTH),
        .AVG_LOG2     (AVG_LOG2),
        .FULL_LEVEL   (FULL_LEVEL),
        .FULL_HYST    (FULL_HYST),
        .CRIT_LEVEL   (CRIT_LEVEL),
        .CRIT_HYST    (CRIT_HYST),
        .TIMEOUT      (TIMEOUT),
        .STALL_CYCLES (STALL_CYCLES)
    ) dut (
        .clock          (clk),
        .reset          (reset),
        .level_sample   (level_sample),
        .sample_valid   (sample_valid),
        .filling        (filling),
        .level_avg      (level_avg),
        .full_tank      (full_tank),
        .critical_level (critical_level),
        .sensor_fault   (sensor_fault),
        .fill_stall     (fill_stall)
    );

    typedef struct {
        int avg;
        bit full;
        bit crit;
        bit fault;
        bit stall;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model: the history of samples since the last window restart.
    int m_win[$];
    int m_cnt, m_idle, m_avg, m_stall_cnt;
    bit m_fault, m_full, m_crit, m_stall;
    bit rst_r, fill_r;

    task automatic chk(input string name, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int window_avg();
        int s = 0;
        foreach (m_win[i]) s += m_win[i];
        return s / WIN;
    endfunction

    task automatic eval_flags(input int a);
        if (a >= FULL_LEVEL) m_full = 1'b1;
        else if (a < FULL_LEVEL - FULL_HYST) m_full = 1'b0;
        if (a <= CRIT_LEVEL) m_crit = 1'b1;
        else if (a > CRIT_LEVEL + CRIT_HYST) m_crit = 1'b0;
    endtask

    task automatic model_edge(input bit rst, input bit sv, input int smp, input bit fill);
        bit was_run;
        int prev_avg;
        if (rst) begin
            m_win.delete();
            m_cnt = 0; m_idle = 0; m_avg = 0; m_stall_cnt = 0;
            m_fault = 0; m_full = 0; m_crit = 0; m_stall = 0;
            return;
        end
        was_run  = !m_fault && (m_cnt >= WIN);
        prev_avg = m_avg;
        // Stall watches the full flag as it stood before this edge.
        if (!fill) begin
            m_stall_cnt = 0;
            m_stall = 0;
        end else if (m_full) begin
            m_stall_cnt = 0;
        end else begin
            if (m_stall_cnt < STALL_CYCLES) m_stall_cnt++;
            if (m_stall_cnt == STALL_CYCLES) m_stall = 1;
        end
        if (!STALL_ON) m_stall = 0;
        if (m_fault) begin
            if (sv) begin
                m_win.delete();
                m_win.push_front(smp);
                m_cnt = 1; m_idle = 0; m_fault = 0;
            end
        end else if (sv) begin
            m_win.push_front(smp);
            if (m_win.size() > WIN) void'(m_win.pop_back());
            if (m_cnt < WIN) m_cnt++;
            m_idle = 0;
            if (was_run) eval_flags(prev_avg);
            else begin m_full = 0; m_crit = 0; end
        end else begin
            m_idle++;
            if (m_idle == TIMEOUT - 1) begin
                m_fault = 1; m_full = 0; m_crit = 0;
            end else if (was_run) begin
                eval_flags(prev_avg);
            end else begin
                m_full = 0; m_crit = 0;
            end
        end
        m_avg = window_avg();
    endtask

    task automatic step(input bit sv, input int smp);
        exp_t e;
        @(negedge clk);
        reset        = rst_r;
        sample_valid = sv;
        filling      = fill_r;
        level_sample = 8'(smp);
        model_edge(rst_r, sv, smp, fill_r);
        e.avg = m_avg; e.full = m_full; e.crit = m_crit; e.fault = m_fault; e.stall = m_stall;
        exp_q.push_back(e);
    endtask

    task automatic feed(input int v);
        step(1'b1, v);
        step(1'b0, 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        rst_r = 1'b1;
        step(1'b0, 0);
        rst_r = 1'b0;
    endtask

    // Monitor: every clocked cycle with an issued stimulus has one expected record.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("level_avg",      int'(level_avg),      mon_e.avg);
                chk("full_tank",      int'(full_tank),      int'(mon_e.full));
                chk("critical_level", int'(critical_level), int'(mon_e.crit));
                chk("sensor_fault",   int'(sensor_fault),   int'(mon_e.fault));
                chk("fill_stall",     int'(fill_stall),     int'(mon_e.stall));
            end
        end
    end

    initial begin
        int level;
        int v;
        reset = 1'b1; sample_valid = 1'b0; filling = 1'b0; level_sample = '0;
        rst_r = 1'b0; fill_r = 1'b0;

        pulse_reset();
        settle();
        chk("reset_avg",   int'(level_avg), 0);
        chk("reset_full",  int'(full_tank), 0);
        chk("reset_crit",  int'(critical_level), 0);
        chk("reset_fault", int'(sensor_fault), 0);
        chk("reset_stall", int'(fill_stall), 0);

        // Warmup: four samples of 210, one per three cycles.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 210);
            settle();
            chk("warmup_full_low", int'(full_tank), 0);
            if (i < 3) begin
                step(1'b0, 0);
                step(1'b0, 0);
            end
        end
        chk("warmup_avg", int'(level_avg), 210);
        step(1'b0, 0);
        settle();
        chk("warmup_full_set", int'(full_tank), 1);

        // Full hysteresis.
        for (int i = 0; i < 4; i++) feed(195);
        settle();
        chk("hyst195_full", int'(full_tank), 1);
        chk("hyst195_avg", int'(level_avg), 195);
        feed(185); feed(185);
        settle();
        chk("hyst190_full_hold", int'(full_tank), 1);
        feed(185);
        settle();
        chk("hyst187_full_clr", int'(full_tank), 0);
        feed(185);

        // Critical hysteresis.
        for (int i = 0; i < 4; i++) feed(30);
        settle();
        chk("crit30_set", int'(critical_level), 1);
        for (int i = 0; i < 4; i++) feed(45);
        settle();
        chk("crit45_hold", int'(critical_level), 1);
        chk("crit45_avg", int'(level_avg), 45);
        feed(60);
        settle();
        chk("crit48_hold", int'(critical_level), 1);
        feed(60);
        settle();
        chk("crit52_clr", int'(critical_level), 0);

        // Timeout.
        for (int i = 0; i < 4; i++) feed(210);
        settle();
        chk("to_full_before", int'(full_tank), 1);
        for (int i = 0; i < 13; i++) step(1'b0, 0);
        settle();
        chk("to_no_fault_14", int'(sensor_fault), 0);
        step(1'b0, 0);
        settle();
        chk("to_fault_15", int'(sensor_fault), 1);
        chk("to_full_forced", int'(full_tank), 0);
        chk("to_avg_hold", int'(level_avg), 210);
        step(1'b1, 210);
        settle();
        chk("to_fault_clr", int'(sensor_fault), 0);
        chk("to_restart_avg", int'(level_avg), 52);
        for (int i = 0; i < 14; i++) step(1'b0, 0);
        step(1'b1, 80);
        settle();
        chk("to_expiry_sample", int'(sensor_fault), 0);
        chk("to_expiry_avg", int'(level_avg), 72);

        // Fill stall with the average stuck at 100.
        pulse_reset();
        for (int i = 0; i < 4; i++) feed(100);
        fill_r = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(k % 5 == 0, 100);
            if (k == 19) begin
                settle();
                chk("stall_19", int'(fill_stall), 0);
            end
        end
        settle();
        chk("stall_20", int'(fill_stall), int'(STALL_ON));
        fill_r = 1'b0;
        step(1'b0, 0);
        settle();
        chk("stall_release", int'(fill_stall), 0);

        // Reset mid-RUN with critical_level set.
        for (int i = 0; i < 4; i++) feed(30);
        settle();
        chk("rst_crit_before", int'(critical_level), 1);
        pulse_reset();
        settle();
        chk("rst_crit_cleared", int'(critical_level), 0);
        chk("rst_avg_cleared", int'(level_avg), 0);
        for (int i = 0; i < 3; i++) feed(30);
        settle();
        chk("rst_warm_3", int'(critical_level), 0);
        feed(30);
        settle();
        chk("rst_warm_4", int'(critical_level), 1);

        // Randomised phase: drifting level with jumps, gaps, fill toggles and resets.
        level = 120;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                pulse_reset();
            end else if ($urandom_range(0, 199) == 0) begin
                repeat (20) step(1'b0, 0);
            end else begin
                if ($urandom_range(0, 49) == 0) fill_r = ~fill_r;
                if ($urandom_range(0, 99) == 0) level = int'($urandom_range(0, 255));
                level = level + int'($urandom_range(0, 16)) - 8;
                if (level < 0) level = 0;
                if (level > 255) level = 255;
                v = level + int'($urandom_range(0, 6)) - 3;
                if (v < 0) v = 0;
                if (v > 255) v = 255;
                step($urandom_range(0, 2) == 0, v);
            end
        end

        settle();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
